gf2_poly_divider: RTL and testbench

GF2_POLY_DIVIDER -- requirements
Module: gf2_poly_divider

---
 rtl/gf2_pkg.sv | 26 ++
 rtl/gf2_div_step.sv | 20 ++
 rtl/gf2_poly_divider.sv | 119 +++++++++++
 tb/tb_gf2_poly_divider.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gf2_pkg.sv
// Shared definitions for the GF(2) polynomial divider: default widths,
// controller state encoding and a carry-less multiply helper.
package gf2_pkg;

    localparam int NA_DEF = 73;                  // dividend width
    localparam int NB_DEF = 41;                  // divisor width
    localparam int QW_DEF = NA_DEF - NB_DEF + 1; // quotient width (33)
    localparam int RW_DEF = NB_DEF - 1;          // remainder width (40)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Carry-less (XOR) product of two polynomials over GF(2).
    function automatic logic [127:0] clmul(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] acc;
        acc = '0;
        for (int i = 0; i < 64; i++) begin
            if (y[i]) acc = acc ^ ({64'b0, x} << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf2_div_step.sv
// One iteration of GF(2) long division: bring down the next dividend bit,
// and if the leading coefficient is set, cancel it with the divisor.
module gf2_div_step #(
    parameter int NB = 41
) (
    input  logic [NB-2:0] rem,       // current partial remainder
    input  logic          abit,      // next dividend bit brought down
    input  logic [NB-2:0] b_low,     // divisor without its (always 1) leading bit
    output logic          qbit,      // quotient bit produced this step
    output logic [NB-2:0] rem_next   // reduced partial remainder
);

    // The leading bit of {rem, abit} is rem's MSB; XOR with the divisor clears
    // it, so only the low NB-1 bits of the reduced word need computing.
    always_comb begin
        qbit     = rem[NB-2];
        rem_next = {rem[NB-3:0], abit} ^ (qbit ? b_low : '0);
    end

endmodule

// File: rtl/gf2_poly_divider.sv
// Sequential GF(2) polynomial divider: one quotient bit per clock.
// a = clmul(q, b) XOR r with deg(r) < NB-1. An illegal divisor (b[NB-1]=0)
// completes one cycle after acceptance with q=0, r=0 and div_err=1.
module gf2_poly_divider
    import gf2_pkg::*;
#(
    parameter int NA = NA_DEF,
    parameter int NB = NB_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NA-1:0]     a,
    input  logic [NB-1:0]     b,
    output logic              busy,
    output logic              done,
    output logic [NA-NB:0]    q,
    output logic [NB-2:0]     r,
    output logic              div_err
);

    localparam int QW = NA - NB + 1;
    localparam int RW = NB - 1;
    localparam int CW = $clog2(QW + 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   rem;
    logic [RW-1:0]   rem_next;
    logic [RW-1:0]   b_lat;
    logic [QW-1:0]   a_sr;
    logic [QW-1:0]   qsr;
    logic            qbit;
    logic            err_pend;
    logic            accept;
    logic            last;

    // A request is taken whenever no division is running, including the FIN
    // cycle, which gives back-to-back throughput of one division per QW+1 cycles.
    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(QW - 1));

    gf2_div_step #(.NB(NB)) u_step (
        .rem      (rem),
        .abit     (a_sr[QW-1]),
        .b_low    (b_lat),
        .qbit     (qbit),
        .rem_next (rem_next)
    );

    // Next-state and status decode. An illegal divisor spends one busy cycle
    // in RUN (no iterations, err_pend set) so its completion lands one cycle
    // after acceptance, with start ignored in between.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (err_pend || last) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset dominates any simultaneous start.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand latch, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            b_lat    <= '0;
            a_sr     <= '0;
            qsr      <= '0;
            err_pend <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_err  <= 1'b0;
        end else if (accept) begin
            a_sr     <= a[QW-1:0];
            b_lat    <= b[RW-1:0];
            rem      <= a[NA-1:QW];
            cnt      <= '0;
            qsr      <= '0;
            err_pend <= ~b[NB-1];
        end else if (state == RUN) begin
            if (err_pend) begin
                q        <= '0;
                r        <= '0;
                div_err  <= 1'b1;
                err_pend <= 1'b0;
            end else begin
                rem  <= rem_next;
                a_sr <= {a_sr[QW-2:0], 1'b0};
                qsr  <= {qsr[QW-2:0], qbit};
                cnt  <= cnt + 1'b1;
                if (last) begin
                    q       <= {qsr[QW-2:0], qbit};
                    r       <= rem_next;
                    div_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Scoreboard bench for gf2_poly_divider: a driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_gf2_poly_divider;
    import gf2_pkg::*;

    localparam int NA = 73;
    localparam int NB = 41;
    localparam int QW = NA - NB + 1;
    localparam int RW = NB - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NA-1:0] a = '0;
    logic [NB-1:0] b = '0;
    logic          busy, done, div_err;
    logic [QW-1:0] q;
    logic [RW-1:0] r;

    gf2_poly_divider #(.NA(NA), .NB(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .div_err(div_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [QW-1:0] q;
        logic [RW-1:0] r;
        logic          err;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Textbook long division: cancel the highest set term with a shifted
    // divisor until the degree drops below that of the divisor.
    task automatic ref_div(input logic [NA-1:0] av, input logic [NB-1:0] bv,
                           output logic [QW-1:0] qv, output logic [RW-1:0] rv, output logic ev);
        logic [NA-1:0] rm;
        qv = '0;
        rv = '0;
        ev = ~bv[NB-1];
        if (!ev) begin
            rm = av;
            for (int i = NA - 1; i >= NB - 1; i--) begin
                if (rm[i]) begin
                    rm = rm ^ (NA'(bv) << (i - (NB - 1)));
                    qv[i-(NB-1)] = 1'b1;
                end
            end
            rv = rm[RW-1:0];
        end
    endtask

    // Called at #1 after a rising edge; waits for a free slot, issues one
    // request and (optionally) records what the DUT must return.
    task automatic issue(input logic [NA-1:0] av, input logic [NB-1:0] bv,
                         input logic [QW-1:0] eq, input logic [RW-1:0] er,
                         input logic ee, input bit push);
        int g = 0;
        exp_t e;
        while (busy && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy) begin
            n_cmp++; n_err++;
            $display("FAIL issue_wait: busy still %0b after %0d cycles, expected 0", busy, g);
        end
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) begin
            e.q = eq; e.r = er; e.err = ee; e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic issue_model(input logic [NA-1:0] av, input logic [NB-1:0] bv);
        logic [QW-1:0] qv;
        logic [RW-1:0] rv;
        logic ev;
        ref_div(av, bv, qv, rv, ev);
        issue(av, bv, qv, rv, ev, 1'b1);
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done: done=1 with no request pending, expected done=0");
            end else begin
                e = sb.pop_front();
                chk("q", 128'(q), 128'(e.q));
                chk("r", 128'(r), 128'(e.r));
                chk("div_err", 128'(div_err), 128'(e.err));
                chk("busy_at_done", 128'(busy), 128'(0));
                chk("latency", 128'(cyc - e.acc), 128'(e.err ? 1 : QW));
                if (!e.err)
                    chk("identity", clmul(64'(q), 64'(dut.b_lat) | (64'(1) << RW)) ^ 128'(r),
                        clmul(64'(e.q), 64'(1) << RW | 64'(dut.b_lat)) ^ 128'(e.r));
            end
        end
    end

    initial begin
        logic [NA-1:0] av;
        logic [NB-1:0] bv;
        logic [QW-1:0] qk;
        logic [RW-1:0] rk;
        logic [127:0]  prod;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_q", 128'(q), 128'(0));
        chk("rst_r", 128'(r), 128'(0));
        chk("rst_div_err", 128'(div_err), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero dividend
        issue('0, (41'(1) << 40) | 41'(1), '0, '0, 1'b0, 1'b1);
        // x^72 / (x^40 + 1)
        issue(73'(1) << 72, (41'(1) << 40) | 41'(1), 33'(1) << 32, 40'(1) << 32, 1'b0, 1'b1);
        // Known quotient and remainder
        bv   = 41'h100_0000_0003;
        qk   = 33'h1_2345_6789;
        rk   = 40'hAB_CDEF_0123;
        prod = clmul(64'(qk), 64'(bv)) ^ 128'(rk);
        issue(prod[NA-1:0], bv, qk, rk, 1'b0, 1'b1);
        // Illegal divisor, then a legal one clears div_err
        issue(73'h1_FFFF_0000_1234_5678, 41'h123, '0, '0, 1'b1, 1'b1);
        drain();
        chk("err_held", 128'(div_err), 128'(1));
        issue_model(73'h0_DEAD_BEEF_CAFE_F00D, 41'h1AA_5555_1234);
        drain();

        // Start during RUN is ignored; operand changes do not leak in
        issue_model(73'h1_0F0F_1234_89AB_CDEF, 41'h1C0_FFEE_0101);
        repeat (9) @(posedge clk);
        #1;
        a = 73'h0_1111_2222_3333_4444; b = 41'h1FF_FFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = '1; b = '0;
        drain();

        // Random traffic, back-to-back (each new start lands in the done cycle)
        for (int i = 0; i < 40; i++) begin
            av = NA'({$urandom(), $urandom(), $urandom()});
            bv = NB'({$urandom(), $urandom()});
            bv[NB-1] = ($urandom_range(0, 7) != 0);
            issue_model(av, bv);
        end
        drain();

        // Reset in the middle of a division: no done, outputs cleared
        issue(73'h1_2222_3333_4444_5555, 41'h155_0000_00FF, '0, '0, 1'b0, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
        chk("midrst_q", 128'(q), 128'(0));
        chk("midrst_r", 128'(r), 128'(0));
        chk("midrst_div_err", 128'(div_err), 128'(0));
        repeat (40) @(posedge clk);
        #1;
        issue_model(73'h0_ABCD_EF01_2345_6789, 41'h10F_0000_F00F);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
